// File: rtl/decode_stage.sv
// decode_stage: decodes 16-bit instructions, tracks pending writes, issues one registered bundle to execute.
// Ports: i_clk/i_reset (async, active-low); i_inst/i_inst_valid/o_inst_ready fetch handshake;
// o_read_reg1/2 + i_read_data1/2 register-file read; i_write_en/add/data writeback;
// o_opcode/o_srcdata_1/o_srcdata_2/o_destadd/o_valid/i_ready issue handshake; o_illegal_cnt drop count.
module decode_stage (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [15:0] i_inst,
  input  logic       i_inst_valid,
  output logic       o_inst_ready,
  output logic [3:0] o_read_reg1,
  output logic [3:0] o_read_reg2,
  input  logic [7:0] i_read_data1,
  input  logic [7:0] i_read_data2,
  input  logic       i_write_en,
  input  logic [3:0] i_write_add,
  input  logic [7:0] i_write_data,
  output logic [3:0] o_opcode,
  output logic [7:0] o_srcdata_1,
  output logic [7:0] o_srcdata_2,
  output logic [3:0] o_destadd,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_illegal_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic [3:0] opcode_q, opcode_d, destadd_q, destadd_d;
  logic [7:0] src1_q, src1_d, src2_q, src2_d, illegal_cnt_q, illegal_cnt_d;
  logic [3:0] op, dest, src1, src2;
  logic legal, two_src, byp1, byp2, hazard, accept, issue;
  assign op = i_inst[15:12];
  assign dest = i_inst[11:8];
  assign src1 = i_inst[7:4];
  assign src2 = i_inst[3:0];
  assign legal = op == 4'b0001 || op == 4'b0010 || op == 4'b0100 || op == 4'b1000;
  assign two_src = op == 4'b0001 || op == 4'b0010;
  assign byp1 = i_write_en && i_write_add == src1;
  assign byp2 = i_write_en && i_write_add == src2;
  // A writeback landing this cycle resolves the pending source, so it is not a hazard.
  assign hazard = i_inst_valid && legal && ((pend_q[src1] && !byp1) || (two_src && pend_q[src2] && !byp2));
  assign o_valid = state_q == FULL;
  assign o_inst_ready = (!o_valid || i_ready) && !hazard;
  assign accept = i_inst_valid && o_inst_ready;
  assign issue = accept && legal;
  assign o_read_reg1 = src1;
  assign o_read_reg2 = src2;
  assign o_opcode = opcode_q;
  assign o_srcdata_1 = src1_q;
  assign o_srcdata_2 = src2_q;
  assign o_destadd = destadd_q;
  assign o_illegal_cnt = illegal_cnt_q;
  always_comb begin
    state_d = (o_valid && !i_ready) || issue ? FULL : EMPTY;
    opcode_d = issue ? op : opcode_q;
    destadd_d = issue ? dest : destadd_q;
    src1_d = issue ? (byp1 ? i_write_data : i_read_data1) : src1_q;
    src2_d = issue ? (!two_src ? 8'h00 : byp2 ? i_write_data : i_read_data2) : src2_q;
    illegal_cnt_d = accept && !legal && illegal_cnt_q != 8'hFF ? illegal_cnt_q + 8'd1 : illegal_cnt_q;
    pend_d = pend_q;
    // Clear first so a same-cycle set on the same register wins.
    if (i_write_en) pend_d[i_write_add] = 1'b0;
    if (issue) pend_d[dest] = 1'b1;
  end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state_q <= EMPTY;
      pend_q <= '0;
      opcode_q <= '0;
      destadd_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      opcode_q <= opcode_d;
      destadd_q <= destadd_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage against a behavioural model.
module tb_decode_stage;
  logic clk = 0, rst_n = 1;
  logic [15:0] i_inst = '0;
  logic i_inst_valid = 0, i_write_en = 0, i_ready = 1;
  logic [3:0] i_write_add = '0;
  logic [7:0] i_write_data = '0;
  logic o_inst_ready, o_valid;
  logic [3:0] o_read_reg1, o_read_reg2, o_opcode, o_destadd;
  logic [7:0] i_read_data1, i_read_data2, o_srcdata_1, o_srcdata_2, o_illegal_cnt;
  logic [7:0] rf [16];
  typedef struct packed {logic [3:0] op; logic [7:0] s1; logic [7:0] s2; logic [3:0] d;} bundle_t;
  bundle_t exp_q[$];
  logic [15:0] pend_m;
  logic mvalid;
  logic [7:0] mcnt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign i_read_data1 = rf[o_read_reg1];
  assign i_read_data2 = rf[o_read_reg2];
  decode_stage dut (
    .i_clk(clk), .i_reset(rst_n), .i_inst(i_inst), .i_inst_valid(i_inst_valid),
    .o_inst_ready(o_inst_ready), .o_read_reg1(o_read_reg1), .o_read_reg2(o_read_reg2),
    .i_read_data1(i_read_data1), .i_read_data2(i_read_data2), .i_write_en(i_write_en),
    .i_write_add(i_write_add), .i_write_data(i_write_data), .o_opcode(o_opcode),
    .o_srcdata_1(o_srcdata_1), .o_srcdata_2(o_srcdata_2), .o_destadd(o_destadd),
    .o_valid(o_valid), .i_ready(i_ready), .o_illegal_cnt(o_illegal_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    mvalid = 0;
    pend_m = '0;
    mcnt = '0;
    exp_q.delete();
  endtask
  task automatic drive(input logic v, input logic [15:0] inst, input logic we, input logic [3:0] wa, input logic [7:0] wd);
    i_inst_valid = v;
    i_inst = inst;
    i_write_en = we;
    i_write_add = wa;
    i_write_data = wd;
  endtask
  task automatic step();
    logic [3:0] op, d, s1, s2;
    logic legal, b1, b2, hz, er, acc;
    bundle_t b;
    @(negedge clk);
    op = i_inst[15:12]; d = i_inst[11:8]; s1 = i_inst[7:4]; s2 = i_inst[3:0];
    legal = op == 4'h1 || op == 4'h2 || op == 4'h4 || op == 4'h8;
    b1 = i_write_en && i_write_add == s1;
    b2 = i_write_en && i_write_add == s2;
    hz = i_inst_valid && legal && ((pend_m[s1] && !b1) || ((op == 4'h1 || op == 4'h2) && pend_m[s2] && !b2));
    er = (!mvalid || i_ready) && !hz;
    chk("inst_ready", o_inst_ready, er);
    chk("valid", o_valid, mvalid);
    chk("illegal_cnt", o_illegal_cnt, mcnt);
    chk("read_reg1", o_read_reg1, s1);
    chk("read_reg2", o_read_reg2, s2);
    if (mvalid) begin
      if (exp_q.size() == 0) chk("sb_underflow", 0, 1);
      else begin
        b = exp_q[0];
        chk("opcode", o_opcode, b.op);
        chk("srcdata_1", o_srcdata_1, b.s1);
        chk("srcdata_2", o_srcdata_2, b.s2);
        chk("destadd", o_destadd, b.d);
        if (i_ready) void'(exp_q.pop_front());
      end
    end
    acc = i_inst_valid && er;
    if (acc && legal)
      exp_q.push_back({op, b1 ? i_write_data : rf[s1],
                       (op == 4'h4 || op == 4'h8) ? 8'h00 : b2 ? i_write_data : rf[s2], d});
    if (acc && !legal && mcnt != 8'hFF) mcnt++;
    mvalid = (mvalid && !i_ready) || (acc && legal);
    if (i_write_en) begin
      pend_m[i_write_add] = 0;
      rf[i_write_add] = i_write_data;
    end
    if (acc && legal) pend_m[d] = 1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'(i * 3 + 1);
    rf[1] = 8'd5; rf[2] = 8'd7; rf[5] = 8'h81;
    model_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_opcode", o_opcode, 0);
    chk("rst_src1", o_srcdata_1, 0);
    chk("rst_src2", o_srcdata_2, 0);
    chk("rst_dest", o_destadd, 0);
    chk("rst_cnt", o_illegal_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // ADD r3,r1,r2 then SUB r4,r3,r1 stalls until r3 writeback bypasses
    drive(1, 16'h1312, 0, 0, 0); step();
    chk("add_valid", o_valid, 1);
    chk("add_src1", o_srcdata_1, 5);
    chk("add_src2", o_srcdata_2, 7);
    drive(1, 16'h2431, 0, 0, 0); step(); step();
    drive(1, 16'h2431, 1, 3, 8'd12); step();
    chk("sub_bypass", o_srcdata_1, 12);
    // backpressure for 3 cycles, then release
    i_ready = 0;
    drive(1, 16'h1712, 0, 0, 0); step(); step(); step();
    i_ready = 1; step();
    drive(0, 0, 0, 0, 0); step(); step();
    // illegal flood; random sources may hit pending registers yet must not stall
    for (int i = 0; i < 300; i++) begin
      drive(1, {4'b0011, 12'($urandom)}, 0, 0, 0); step();
    end
    chk("cnt_sat", o_illegal_cnt, 8'hFF);
    drive(1, 16'h1040, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    // LS r5,r5 and LS with pending src2 ignored
    drive(1, 16'h4550, 0, 0, 0); step();
    chk("ls_src1", o_srcdata_1, 8'h81);
    chk("ls_src2", o_srcdata_2, 0);
    drive(1, 16'h1850, 0, 0, 0); step();
    drive(1, 16'h4A14, 0, 0, 0); step();
    drive(1, 16'h8B27, 0, 0, 0); step();
    // set wins over clear on r6
    drive(1, 16'h1612, 0, 0, 0); step();
    drive(1, 16'h1612, 1, 6, 8'h33); step();
    drive(1, 16'h1960, 1, 2, 8'h44); step();
    drive(1, 16'h1960, 1, 6, 8'h55); step();
    drive(0, 0, 0, 0, 0); step();
    // reset with a stalled bundle in flight
    drive(1, 16'h1C12, 0, 0, 0); step();
    i_ready = 0; drive(0, 0, 0, 0, 0); step();
    rst_n = 0;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_cnt", o_illegal_cnt, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1; i_ready = 1;
    drive(1, 16'h1D40, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step(); step();
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
